// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep of the universal inputs of a Skolem netlist, counting
// assignments where the spec evaluator reports a violation and capturing the first.
module skolem_sweep_checker #(
    parameter int NUM_X = 5,
    parameter int NUM_Y = 2,
    parameter int LAT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [NUM_X-1:0]   x_out,
    input  logic [NUM_Y-1:0]   y_in,
    input  logic               spec_ok,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_X:0]     fail_count,
    output logic               first_fail_valid,
    output logic [NUM_X-1:0]   first_fail_x,
    output logic [NUM_Y-1:0]   first_fail_y
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam logic [NUM_X-1:0] X_LAST     = '1;
    localparam logic [NUM_X-1:0] X_ONE      = NUM_X'(1);
    localparam logic [NUM_X:0]   FC_ONE     = (NUM_X+1)'(1);
    localparam logic [2:0]       DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    state_t             state_q, state_d;
    logic [NUM_X-1:0]   x_out_q, x_out_d;
    logic [NUM_X:0]     fail_count_q, fail_count_d;
    logic               ff_valid_q, ff_valid_d;
    logic [NUM_X-1:0]   ff_x_q, ff_x_d;
    logic [NUM_Y-1:0]   ff_y_q, ff_y_d;
    logic [2:0]         drain_cnt_q, drain_cnt_d;

    logic               tag_v;
    logic [NUM_X-1:0]   tag_x;
    logic               launch;

    assign launch = start && (state_q == IDLE || state_q == DONE);

    // Tag pipeline: each presented x travels alongside the netlist latency so
    // y_in/spec_ok are attributed to the x that produced them.
    generate
        if (LAT == 0) begin : g_no_pipe
            assign tag_v = (state_q == SWEEP);
            assign tag_x = x_out_q;
        end else begin : g_pipe
            logic [LAT-1:0]             pv_q, pv_d;
            logic [LAT-1:0][NUM_X-1:0]  px_q, px_d;

            always_comb begin
                pv_d[0] = (state_q == SWEEP);
                px_d[0] = x_out_q;
                for (int i = 1; i < LAT; i++) begin
                    pv_d[i] = pv_q[i-1];
                    px_d[i] = px_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                    px_q <= '0;
                end else begin
                    pv_q <= pv_d;
                    px_q <= px_d;
                end
            end

            assign tag_v = pv_q[LAT-1];
            assign tag_x = px_q[LAT-1];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = SWEEP;
            SWEEP:      if (x_out_q == X_LAST) state_d = (LAT > 0) ? DRAIN : DONE;
            DRAIN:      if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q == SWEEP) || (state_q == DRAIN);
        done = (state_q == DONE);
        pass = (state_q == DONE) && (fail_count_q == '0);
    end

    // Datapath: x counter, drain timer, violation accounting
    always_comb begin
        x_out_d      = x_out_q;
        fail_count_d = fail_count_q;
        ff_valid_d   = ff_valid_q;
        ff_x_d       = ff_x_q;
        ff_y_d       = ff_y_q;
        drain_cnt_d  = 3'd0;
        if (launch) begin
            x_out_d      = '0;
            fail_count_d = '0;
            ff_valid_d   = 1'b0;
            ff_x_d       = '0;
            ff_y_d       = '0;
        end else begin
            if (state_q == SWEEP && x_out_q != X_LAST) x_out_d = x_out_q + X_ONE;
            if (state_q == DRAIN) drain_cnt_d = drain_cnt_q + 3'd1;
            if (tag_v && !spec_ok) begin
                fail_count_d = fail_count_q + FC_ONE;
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_x_d     = tag_x;
                    ff_y_d     = y_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_out_q      <= '0;
            fail_count_q <= '0;
            ff_valid_q   <= 1'b0;
            ff_x_q       <= '0;
            ff_y_q       <= '0;
            drain_cnt_q  <= 3'd0;
        end else begin
            x_out_q      <= x_out_d;
            fail_count_q <= fail_count_d;
            ff_valid_q   <= ff_valid_d;
            ff_x_q       <= ff_x_d;
            ff_y_q       <= ff_y_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign x_out            = x_out_q;
    assign fail_count       = fail_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_x     = ff_x_q;
    assign first_fail_y     = ff_y_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench for skolem_sweep_checker: one LAT=0 and one LAT=2 instance,
// driven by a behavioural Skolem/spec model; run results checked via a scoreboard queue.
module tb_skolem_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       start;
    wire  [1:0][4:0]  x_out;
    wire  [1:0]       busy, done, pass, ffv;
    wire  [1:0][5:0]  fc;
    wire  [1:0][4:0]  ffx;
    wire  [1:0][1:0]  ffy;

    logic             spec_ok0, spec_ok1;
    logic [1:0]       y0, y1;
    int               mode0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         fc;
        logic       ffv;
        logic [4:0] ffx;
        logic [1:0] ffy;
        logic       pass;
    } exp_t;

    exp_t sb[$];

    // d=1 (latency-2 netlist) fails only x=0; d=0 behaviour selected by mode
    function automatic logic ok_f(input int d, input int m, input logic [4:0] x);
        if (d == 1) return x != 5'd0;
        case (m)
            0:       return 1'b1;
            1:       return (x != 5'd7) && (x != 5'd20);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] y_f(input int d, input int m, input logic [4:0] x);
        if (d == 1) return x[1:0] ^ 2'b10;
        return (m == 1) ? 2'b01 : (x[1:0] ^ 2'b11);
    endfunction

    assign spec_ok0 = ok_f(0, mode0, x_out[0]);
    assign y0       = y_f(0, mode0, x_out[0]);

    // Two-register latency model of the netlist feeding the LAT=2 instance
    logic       ok1_p1, ok1_p2;
    logic [1:0] y1_p1, y1_p2;
    always @(posedge clk) begin
        ok1_p1 <= ok_f(1, 0, x_out[1]);
        ok1_p2 <= ok1_p1;
        y1_p1  <= y_f(1, 0, x_out[1]);
        y1_p2  <= y1_p1;
    end
    assign spec_ok1 = ok1_p2;
    assign y1       = y1_p2;

    skolem_sweep_checker #(.NUM_X(5), .NUM_Y(2), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .x_out(x_out[0]),
        .y_in(y0), .spec_ok(spec_ok0), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_count(fc[0]), .first_fail_valid(ffv[0]),
        .first_fail_x(ffx[0]), .first_fail_y(ffy[0])
    );

    skolem_sweep_checker #(.NUM_X(5), .NUM_Y(2), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .x_out(x_out[1]),
        .y_in(y1), .spec_ok(spec_ok1), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_count(fc[1]), .first_fail_valid(ffv[1]),
        .first_fail_x(ffx[1]), .first_fail_y(ffy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input int d);
        chk("rst_x_out", 32'(x_out[d]), 0);
        chk("rst_busy", 32'(busy[d]), 0);
        chk("rst_done", 32'(done[d]), 0);
        chk("rst_pass", 32'(pass[d]), 0);
        chk("rst_fc", 32'(fc[d]), 0);
        chk("rst_ffv", 32'(ffv[d]), 0);
        chk("rst_ffx", 32'(ffx[d]), 0);
        chk("rst_ffy", 32'(ffy[d]), 0);
    endtask

    // One full sweep; restart_k >= 0 re-pulses start while x=restart_k is presented
    task automatic run(input int d, input int m, input int restart_k);
        exp_t e;
        int   lat;
        lat = (d == 1) ? 2 : 0;
        if (d == 0) mode0 = m;
        e.fc = 0; e.ffv = 1'b0; e.ffx = '0; e.ffy = '0;
        for (int x = 0; x < 32; x++) begin
            if (!ok_f(d, m, 5'(x))) begin
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffx = 5'(x);
                    e.ffy = y_f(d, m, 5'(x));
                end
                e.fc++;
            end
        end
        e.pass = (e.fc == 0);
        sb.push_back(e);

        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        chk("start_clr_fc", 32'(fc[d]), 0);
        chk("start_clr_ffv", 32'(ffv[d]), 0);
        chk("start_clr_done", 32'(done[d]), 0);
        for (int k = 0; k < 32; k++) begin
            chk("sweep_x_out", 32'(x_out[d]), 32'(k));
            chk("sweep_busy", 32'(busy[d]), 1);
            if (k == restart_k) start[d] = 1'b1;
            tick();
            start[d] = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin
            chk("drain_busy", 32'(busy[d]), 1);
            chk("drain_done", 32'(done[d]), 0);
            chk("drain_x_hold", 32'(x_out[d]), 31);
            tick();
        end
        chk("done_rise", 32'(done[d]), 1);
        chk("done_busy", 32'(busy[d]), 0);
        e = sb.pop_front();
        chk("fail_count", 32'(fc[d]), 32'(e.fc));
        chk("first_fail_valid", 32'(ffv[d]), 32'(e.ffv));
        chk("first_fail_x", 32'(ffx[d]), 32'(e.ffx));
        chk("first_fail_y", 32'(ffy[d]), 32'(e.ffy));
        chk("pass", 32'(pass[d]), 32'(e.pass));
        tick();
        chk("done_held", 32'(done[d]), 1);
        chk("done_x_hold", 32'(x_out[d]), 31);
    endtask

    initial begin
        rst   = 2'b11;
        start = 2'b00;
        mode0 = 0;
        repeat (3) tick();
        chk_idle_reset(0);
        chk_idle_reset(1);
        rst = 2'b00;
        repeat (6) tick();

        run(0, 0, -1);   // all pass
        run(0, 1, -1);   // violations at x=7 and x=20
        run(0, 0, 4);    // restart from DONE clears counters; mid-sweep start ignored
        run(0, 2, -1);   // spec_ok tied low: every assignment fails
        run(1, 0, -1);   // latency 2, only x=0 fails; early sampling would add fails

        // Reset in the middle of a failing sweep
        mode0 = 1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (14) tick();
        chk("pre_rst_x_out", 32'(x_out[0]), 14);
        chk("pre_rst_ffv", 32'(ffv[0]), 1);
        chk("pre_rst_fc", 32'(fc[0]), 1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk_idle_reset(0);
        repeat (3) tick();
        chk("idle_x_out", 32'(x_out[0]), 0);
        chk("idle_busy", 32'(busy[0]), 0);
        run(0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
